// File: rtl/bcd_serial_add_ctrl_if.sv
// Request/result bundle for the digit-serial BCD adder controller.
// The master drives the operands and start; the slave returns status and result.
interface bcd_serial_add_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  err;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, err
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, err
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial multi-digit BCD adder: one shared single-digit stage walks LSD to MSD,
// one digit per clock, then presents a registered sum/carry/error with a done pulse.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned IDXW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_serial_add_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int unsigned W = 4 * DIGITS;

    state_t          state_q, state_d;
    logic [W-1:0]    opa_q, opa_d;
    logic [W-1:0]    opb_q, opb_d;
    logic            carry_q, carry_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    psum_q, psum_d;
    logic            err_pend_q, err_pend_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    logic [3:0]      dig_a, dig_b, dig_res;
    logic [4:0]      t_raw, t_adj;
    logic            carry_nx;
    logic [W-1:0]    psum_wr;
    logic            err_in;

    // Shared single-digit decimal stage on the currently indexed digit.
    always_comb begin
        dig_a    = opa_q[{idx_q, 2'b00} +: 4];
        dig_b    = opb_q[{idx_q, 2'b00} +: 4];
        t_raw    = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, carry_q};
        t_adj    = t_raw + 5'd6;
        carry_nx = (t_raw > 5'd9);
        dig_res  = carry_nx ? t_adj[3:0] : t_raw[3:0];
    end

    always_comb begin
        psum_wr = psum_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                psum_wr[4*i +: 4] = dig_res;
            end
        end
    end

    always_comb begin
        err_in = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if ((bus.a[4*i +: 4] > 4'd9) || (bus.b[4*i +: 4] > 4'd9)) begin
                err_in = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        psum_d     = psum_q;
        err_pend_d = err_pend_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_RUN;
                    opa_d      = bus.a;
                    opb_d      = bus.b;
                    carry_d    = bus.cin;
                    idx_d      = '0;
                    psum_d     = '0;
                    err_pend_d = err_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                psum_d  = psum_wr;
                carry_d = carry_nx;
                // The final digit goes straight into sum so results appear on the DONE-entry edge.
                if (idx_q == IDXW'(DIGITS - 1)) begin
                    state_d = S_DONE;
                    sum_d   = psum_wr;
                    cout_d  = carry_nx;
                    err_d   = err_pend_q;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            opa_q      <= '0;
            opb_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            psum_q     <= '0;
            err_pend_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            psum_q     <= psum_d;
            err_pend_q <= err_pend_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            err_q      <= err_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Bench for the digit-serial BCD adder: decimal-arithmetic reference model with
// a per-cycle compare, directed literal cases and randomized operation streams.
module tb_bcd_serial_add_ctrl;
    localparam int unsigned D = 4;
    localparam int unsigned W = 4 * D;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    bcd_serial_add_ctrl_if #(.DIGITS(D)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(D), .IDXW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal reference: convert to integers, add, convert back.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        longint vx = 0, vy = 0, p = 1, s, tot;
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            vx += longint'(x[4*i +: 4]) * p;
            vy += longint'(y[4*i +: 4]) * p;
            p  *= 10;
        end
        tot = vx + vy + longint'(c);
        s   = tot;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(s % 10);
            s = s / 10;
        end
        return {(tot >= p), r};
    endfunction

    function automatic bit has_bad(input logic [W-1:0] x);
        for (int i = 0; i < D; i++)
            if (x[4*i +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] rnd_bcd(input bit allow_bad);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++)
            r[4*i +: 4] = (allow_bad && ($urandom % 12 == 0)) ? 4'($urandom_range(10, 15))
                                                              : 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Model: cycles remaining of an accepted op, plus expected output registers.
    int           m_cnt   = 0;
    bit           m_done  = 1'b0;
    logic [W-1:0] m_sum   = '0;
    bit           m_cout  = 1'b0;
    bit           m_err   = 1'b0;
    bit           m_known = 1'b1;
    logic [W-1:0] p_sum   = '0;
    bit           p_cout  = 1'b0;
    bit           p_err   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_err = 1'b0; m_known = 1'b1;
        end else begin
            m_done = 1'b0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done  = 1'b1;
                    m_sum   = p_sum;
                    m_cout  = p_cout;
                    m_err   = p_err;
                    m_known = !p_err;
                end
            end else if (bus.start === 1'b1) begin
                m_cnt = D;
                {p_cout, p_sum} = ref_add(bus.a, bus.b, bus.cin);
                p_err = has_bad(bus.a) || has_bad(bus.b);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(bus.busy), 32'(m_cnt > 0));
        chk("done", 32'(bus.done), 32'(m_done));
        chk("err",  32'(bus.err),  32'(m_err));
        if (m_known) begin
            chk("sum",  32'(bus.sum),  32'(m_sum));
            chk("cout", 32'(bus.cout), 32'(m_cout));
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input string tag, input logic [W-1:0] es, input logic ec,
                         input logic ee, input bit cks);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.a = x; bus.b = y; bus.cin = c;
        @(negedge clk);
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
        lat = 1;
        while (bus.done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(D + 1));
        chk({tag, " err"}, 32'(bus.err), 32'(ee));
        if (cks) begin
            chk({tag, " sum"},  32'(bus.sum),  32'(es));
            chk({tag, " cout"}, 32'(bus.cout), 32'(ec));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone, last;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;

        // Pin the reference model to hand-computed values.
        chk("ref 1234+5678", 32'(ref_add(16'h1234, 16'h5678, 1'b0)), 32'h0_6912);
        chk("ref 9999+0001", 32'(ref_add(16'h9999, 16'h0001, 1'b0)), 32'h1_0000);
        chk("ref 9999+9999+1", 32'(ref_add(16'h9999, 16'h9999, 1'b1)), 32'h1_9999);
        chk("ref 5+5", 32'(ref_add(16'h0005, 16'h0005, 1'b0)), 32'h0_0010);

        repeat (3) @(negedge clk);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset sum",  32'(bus.sum),  32'd0);
        rst_n = 1'b1;

        do_op(16'h1234, 16'h5678, 1'b0, "op1234", 16'h6912, 1'b0, 1'b0, 1'b1);
        do_op(16'h9999, 16'h0001, 1'b0, "op9999p1", 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(16'h9999, 16'h9999, 1'b1, "op9999x2", 16'h9999, 1'b1, 1'b0, 1'b1);

        // Start held high: back-to-back ops every D+1 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 16'h0005; bus.b = 16'h0005; bus.cin = 1'b0;
        ndone = 0; last = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                chk("b2b sum", 32'(bus.sum), 32'h0010);
                if (last > 0) chk("b2b interval", 32'(k - last), 32'(D + 1));
                last = k;
                ndone++;
            end
        end
        chk("b2b count", 32'(ndone), 32'd3);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

        // Start pulse while busy must be ignored.
        bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678; bus.cin = 1'b0;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111;
        @(negedge clk); bus.start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done === 1'b1) begin
                ndone++;
                chk("ignore sum", 32'(bus.sum), 32'h6912);
            end
            @(negedge clk);
        end
        chk("ignore count", 32'(ndone), 32'd1);

        // Asynchronous reset in the middle of an operation.
        bus.start = 1'b1; bus.a = 16'h4321; bus.b = 16'h1111; bus.cin = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst sum",  32'(bus.sum),  32'd0);
        chk("rst cout", 32'(bus.cout), 32'd0);
        chk("rst err",  32'(bus.err),  32'd0);
        @(negedge clk); rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        chk("rst no done", 32'(ndone), 32'd0);
        do_op(16'h0001, 16'h0002, 1'b0, "post rst", 16'h0003, 1'b0, 1'b0, 1'b1);

        // Invalid digit flags err, then clears on a valid op.
        do_op(16'h00A0, 16'h0000, 1'b0, "bad digit", 16'h0000, 1'b0, 1'b1, 1'b0);
        do_op(16'h0001, 16'h0001, 1'b0, "after bad", 16'h0002, 1'b0, 1'b0, 1'b1);

        // Randomized stream: random start rate, operands changing every cycle.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            bus.start = ($urandom % 3 == 0);
            bus.a     = rnd_bcd(1'b1);
            bus.b     = rnd_bcd(1'b1);
            bus.cin   = 1'($urandom);
        end
        bus.start = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
